// File: rtl/rr_burst_arbiter_pkg.sv
// Shared types and helpers for the round-robin burst arbiter and its
// rotate-search sub-block.
package rr_burst_arbiter_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } arb_state_t;

  // Wrap-around increment for requester counts that need not be a power of 2.
  function automatic int unsigned wrap_inc(input int unsigned idx, input int unsigned n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// Combinational rotate-search: first set request at or after start, wrapping
// modulo NUM_FIFOS.
module rr_priority_pick #(
  parameter int NUM_FIFOS = 4,
  parameter int TAGWIDTH  = $clog2(NUM_FIFOS)
) (
  input  logic [NUM_FIFOS-1:0] reqs,
  input  logic [TAGWIDTH-1:0]  start,
  output logic                 found,
  output logic [TAGWIDTH-1:0]  idx
);

  always_comb begin
    int cand;
    // NOTE: every output of a combinational block gets a default before any
    // branch; a path that leaves one unassigned would infer a latch.
    found = 1'b0;
    idx   = '0;
    for (int k = 0; k < NUM_FIFOS; k++) begin
      cand = int'(start) + k;
      if (cand >= NUM_FIFOS) cand = cand - NUM_FIFOS;
      if (!found && reqs[cand]) begin
        found = 1'b1;
        idx   = TAGWIDTH'(cand);
      end
    end
  end

endmodule

// File: rtl/rr_burst_arbiter.sv
// Round-robin arbiter with bounded bursts; the one-hot grant doubles as the
// FIFO pop and the output-mux select, with zero latency from request.
module rr_burst_arbiter
  import rr_burst_arbiter_pkg::*;
#(
  parameter int NUM_FIFOS = 4,
  parameter int MAX_BURST = 2,
  parameter int TAGWIDTH  = $clog2(NUM_FIFOS),
  parameter int CNTWIDTH  = $clog2(MAX_BURST + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_FIFOS-1:0] reqs,
  input  logic                 ready,
  output logic [NUM_FIFOS-1:0] gnt,
  output logic [TAGWIDTH-1:0]  gnt_idx,
  output logic                 gnt_vld,
  output logic                 burst_last
);

  arb_state_t            fsm, fsm_nx;
  logic [TAGWIDTH-1:0]   ptr, ptr_nx;
  logic [TAGWIDTH-1:0]   cur, cur_nx;
  logic [CNTWIDTH-1:0]   cnt, cnt_nx;

  logic [TAGWIDTH-1:0]   search_start;
  logic                  pick_found;
  logic [TAGWIDTH-1:0]   pick_idx;
  logic [TAGWIDTH-1:0]   cur_inc;

  assign cur_inc = TAGWIDTH'(wrap_inc(32'(cur), NUM_FIFOS));

  // A holder that dropped its request hands over in the same cycle, searching
  // from the slot after it.
  assign search_start = (fsm == HOLD) ? cur_inc : ptr;

  rr_priority_pick #(
    .NUM_FIFOS (NUM_FIFOS),
    .TAGWIDTH  (TAGWIDTH)
  ) u_pick (
    .reqs  (reqs),
    .start (search_start),
    .found (pick_found),
    .idx   (pick_idx)
  );

  always_comb begin
    fsm_nx     = fsm;
    ptr_nx     = ptr;
    cur_nx     = cur;
    cnt_nx     = cnt;
    gnt_vld    = 1'b0;
    gnt_idx    = '0;
    burst_last = 1'b0;
    if (!rst && ready) begin
      if (fsm == HOLD && reqs[cur]) begin
        gnt_vld = 1'b1;
        gnt_idx = cur;
        if (cnt == CNTWIDTH'(MAX_BURST - 1)) begin
          burst_last = 1'b1;
          ptr_nx     = cur_inc;
          cnt_nx     = '0;
          fsm_nx     = IDLE;
        end else begin
          cnt_nx = cnt + CNTWIDTH'(1);
        end
      end else if (pick_found) begin
        gnt_vld = 1'b1;
        gnt_idx = pick_idx;
        if (MAX_BURST == 1) begin
          burst_last = 1'b1;
          ptr_nx     = TAGWIDTH'(wrap_inc(32'(pick_idx), NUM_FIFOS));
          fsm_nx     = IDLE;
        end else begin
          cur_nx = pick_idx;
          cnt_nx = CNTWIDTH'(1);
          fsm_nx = HOLD;
        end
      end else if (fsm == HOLD) begin
        ptr_nx = cur_inc;
        cnt_nx = '0;
        fsm_nx = IDLE;
      end
    end
  end

  always_comb begin
    gnt = '0;
    if (gnt_vld) gnt[gnt_idx] = 1'b1;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fsm <= IDLE;
      ptr <= '0;
      cur <= '0;
      cnt <= '0;
    end else begin
      fsm <= fsm_nx;
      ptr <= ptr_nx;
      cur <= cur_nx;
      cnt <= cnt_nx;
    end
  end

  a_onehot : assert property (@(posedge clk) disable iff (rst) $onehot0(gnt));
  a_subset : assert property (@(posedge clk) disable iff (rst) (gnt & ~reqs) == '0);
  a_idle   : assert property (@(posedge clk) disable iff (rst)
                              (!ready || reqs == '0) |-> gnt == '0);
  a_serve  : assert property (@(posedge clk) disable iff (rst)
                              (ready && reqs != '0) |-> gnt_vld);

endmodule

// File: doc/rr_burst_arbiter.md
Name: rr_burst_arbiter

Overview:
- Concrete arbiter for the multi-FIFO datapath. Replaces the abstract arbiter assumptions with real RTL.
- Takes per-FIFO requests, already guarded with ~empty, plus a downstream ready. Drives a one-hot grant that is used directly as the FIFO pop and as the output-mux select.
- Round-robin with a bounded burst: a FIFO keeps the grant for up to MAX_BURST consecutive pops, then priority rotates past it.

Parameters:
- NUM_FIFOS, 4, number of requesters; must be >= 2 and need not be a power of 2.
- MAX_BURST, 2, maximum consecutive grants to one requester; must be >= 1.
- TAGWIDTH, $clog2(NUM_FIFOS), index width.
- CNTWIDTH, $clog2(MAX_BURST+1), burst counter width.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  reset, asynchronous, active-high.
- reqs  input  NUM_FIFOS  per-FIFO request; the caller guarantees reqs[i] implies FIFO i is non-empty.
- ready  input  1  downstream can accept a word this cycle.
- gnt  output  NUM_FIFOS  one-hot or zero grant; combinational from reqs, ready and state; equals pop.
- gnt_idx  output  TAGWIDTH  binary index of gnt; 0 when gnt==0.
- gnt_vld  output  1  gnt != 0.
- burst_last  output  1  the current grant is the final grant of its burst.

Behaviour:
- State registers:
  - fsm in {IDLE, HOLD}.
  - ptr: search start index.
  - cur: holder index.
  - cnt: grants issued in the current burst.
- Reset: fsm=IDLE, ptr=0, cur=0, cnt=0. While rst=1, gnt=0, gnt_vld=0, gnt_idx=0, burst_last=0 regardless of other inputs.
- ready=0: gnt=0 and all state is held. A burst is not broken by backpressure.
- Search(s): first index w scanning s, s+1, ... with wrap modulo NUM_FIFOS (explicit wrap for non-power-of-2) such that reqs[w]=1. Not found means no grant.
- IDLE with ready=1:
  - No request: gnt=0, state unchanged.
  - Otherwise w=Search(ptr) and gnt=1<<w.
  - MAX_BURST==1: ptr<=w+1 mod N, stay IDLE, burst_last=1.
  - Otherwise: cur<=w, cnt<=1, fsm<=HOLD, burst_last=0.
- HOLD with ready=1 and reqs[cur]=1:
  - gnt=1<<cur.
  - If cnt+1==MAX_BURST: burst_last=1, ptr<=cur+1 mod N, cnt<=0, fsm<=IDLE.
  - Else: cnt<=cnt+1.
- HOLD with ready=1 and reqs[cur]=0: the burst ends with no idle cycle. In the same cycle the arbiter acts as IDLE with s=cur+1 mod N.
  - Grant found: that grant starts a new burst, same rules as IDLE.
  - Nothing found: ptr<=cur+1, fsm<=IDLE.
- Invariants (also formal asserts):
  - gnt is one-hot or zero.
  - (gnt & ~reqs)==0.
  - gnt==0 when reqs==0 or ready==0.
  - With ready=1 and reqs!=0, exactly one granted bit, and it is in reqs. This matches the abstract-arbiter contract.
  - gnt_idx is consistent with gnt.
- Fairness: with ready held at 1, a continuously requesting FIFO is granted within (NUM_FIFOS-1)*MAX_BURST cycles.
- Latency: zero. The grant is in the same cycle as the request; state updates on the next edge.

Decomposition:
- Shared package: the fsm state enum (IDLE, HOLD) and a wrap-increment helper function (idx+1 mod NUM_FIFOS).
- One sub-module, rr_priority_pick: a combinational rotate-search that takes reqs and a start index and returns found plus index. It is reusable by the existing round_robin_selector redirect path.
- Everything else lives in the top level.

Test Plan:
- N=4, MAX_BURST=2, reqs=1111, ready=1 from reset release. Required gnt sequence: 0001, 0001, 0010, 0010, 0100, 0100, 1000, 1000, 0001. burst_last=1 on every second grant.
- reqs=0100 held, ready=1. Required: gnt=0100 every cycle, gnt_idx=2, and burst_last pulses every 2nd cycle.
- Grant 0010 with cnt=1, then ready=0 for 3 cycles. Required: gnt=0 for those 3 cycles. Then ready=1 gives gnt=0010 with burst_last=1, and the next grant is 0100.
- Burst on FIFO 0 with cnt=1, then reqs changes to 1010. Required: gnt=0010 in the same cycle with no bubble, starting a new burst on FIFO 1.
- Reset mid-burst: rst asserted between clock edges during a HOLD on FIFO 2. Required: gnt drops to 0 immediately. After release with reqs=1111, the first grant is 0001.
- N=3, MAX_BURST=1, reqs=111. Required: 001, 010, 100, 001 (wrap). Then reqs=000 gives gnt_vld=0 and ptr held.
